// File: rtl/sme_pkg.sv
// ---------------------------------------------------------------------------
// sme_pkg
// Shared definitions for the sme_multi string-matching engine:
//   - metacharacter / separator constants (8-bit ASCII codes)
//   - controller state enumeration
//   - fold_char(): maps ASCII upper case (0x41-0x5A) onto lower case
//     (0x61-0x7A). It is used only when SME_CASE_FOLD_EN is defined.
// ---------------------------------------------------------------------------
package sme_pkg;

  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_DOLLAR = 8'h24;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_STR = 2'd1,
    LOAD_PAT = 2'd2,
    SEARCH   = 2'd3
  } sme_state_e;

  // Characters are passed zero-extended to 32 bits so one function serves
  // any CHAR_W up to 32.
  function automatic logic [31:0] fold_char(input logic [31:0] c);
    if (c >= 32'h41 && c <= 32'h5A) begin
      return c + 32'h20;
    end
    return c;
  endfunction

endpackage

// File: rtl/sme_multi_cmp_lane.sv
// ---------------------------------------------------------------------------
// sme_cmp_lane
// Compares one core-pattern position against one string character.
// Ports:
//   en      in  1       lane in use (position < core length)
//   pat_ch  in  CHAR_W  core pattern character
//   str_ch  in  CHAR_W  string character at the same offset
//   hit     out 1       lane unused, wildcard, or characters equal
// Build option: SME_CASE_FOLD_EN folds both characters to lower case
// before the equality test. The wildcard test always uses the raw
// pattern character.
// ---------------------------------------------------------------------------
module sme_cmp_lane
  import sme_pkg::*;
#(
  parameter int CHAR_W = 8
) (
  input  logic              en,
  input  logic [CHAR_W-1:0] pat_ch,
  input  logic [CHAR_W-1:0] str_ch,
  output logic              hit
);

  logic [CHAR_W-1:0] pat_cmp;
  logic [CHAR_W-1:0] str_cmp;
  logic              is_dot;

`ifdef SME_CASE_FOLD_EN
  assign pat_cmp = CHAR_W'(fold_char(32'(pat_ch)));
  assign str_cmp = CHAR_W'(fold_char(32'(str_ch)));
`else
  assign pat_cmp = pat_ch;
  assign str_cmp = str_ch;
`endif

  assign is_dot = (pat_ch == CHAR_W'(CH_DOT));
  assign hit    = !en || is_dot || (pat_cmp == str_cmp);

endmodule

// File: rtl/sme_multi.sv
// ---------------------------------------------------------------------------
// sme_multi
// Byte-serial string-matching engine. A string burst (isstring) and then
// one or more pattern bursts (ispattern) are loaded; after each pattern
// burst the stored string is scanned one candidate alignment per cycle.
// Supports '.', leading '^' and trailing '$'; first-match and find-all.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   chardata     input character (CHAR_W)
//   isstring     chardata is a string character
//   ispattern    chardata is a pattern character
//   find_all     mode, captured with the first pattern character
//   busy         high during every search cycle
//   valid        one-cycle result strobe
//   match        result qualifier while valid
//   match_index  start index of the match (0 unless valid)
//   done         one-cycle end-of-search strobe
// Build option: SME_CASE_FOLD_EN enables ASCII case folding in the lanes.
// ---------------------------------------------------------------------------
module sme_multi
  import sme_pkg::*;
#(
  parameter int CHAR_W  = 8,
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int IDX_W   = $clog2(STR_MAX + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CHAR_W-1:0] chardata,
  input  logic              isstring,
  input  logic              ispattern,
  input  logic              find_all,
  output logic              busy,
  output logic              valid,
  output logic              match,
  output logic [IDX_W-1:0]  match_index,
  output logic              done
);

  localparam int PW  = $clog2(PAT_MAX + 1);
  localparam int SAW = (STR_MAX > 1) ? $clog2(STR_MAX) : 1;
  localparam int PAW = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;

  localparam logic [CHAR_W-1:0] C_SPACE  = CHAR_W'(CH_SPACE);
  localparam logic [CHAR_W-1:0] C_CARET  = CHAR_W'(CH_CARET);
  localparam logic [CHAR_W-1:0] C_DOLLAR = CHAR_W'(CH_DOLLAR);

  sme_state_e state, state_nxt;

  logic [CHAR_W-1:0] str_mem [STR_MAX];
  logic [CHAR_W-1:0] pat_mem [PAT_MAX];
  logic [IDX_W-1:0]  str_len;
  logic [PW-1:0]     pat_len;
  logic [IDX_W-1:0]  cand_s;
  logic              find_all_r;

  logic              str_wr, str_first, pat_wr, pat_first;
  logic              search_cyc, search_end;
  logic              head_anchor, tail_anchor;
  logic [PW-1:0]     core_len;
  logic [IDX_W-1:0]  ncand;
  logic              cand_live;
  logic              head_ok, tail_ok;
  logic [31:0]       tail_idx;
  logic [PAT_MAX-1:0] lane_hit;
  logic              cand_hit_p0;

  logic              vld_p1;
  logic              match_p1;
  logic [IDX_W-1:0]  idx_p1;
  logic              done_p1;

  // Load qualification. Loading is only accepted outside a search; a string
  // character wins if both qualifiers are raised together.
  always_comb begin
    str_wr     = isstring && (state == IDLE || state == LOAD_STR);
    str_first  = str_wr && (state != LOAD_STR);
    pat_wr     = ispattern && !str_wr && (state != SEARCH);
    pat_first  = pat_wr && (state != LOAD_PAT);
    // The first cycle with ispattern low after a pattern burst already
    // evaluates candidate 0, while the state register still says LOAD_PAT.
    search_cyc = (state == SEARCH) || (state == LOAD_PAT && !ispattern);
  end

  // Pattern decode from the stored pattern
  always_comb begin
    head_anchor = (pat_len != '0) && (pat_mem[0] == C_CARET);
    tail_anchor = (pat_len != '0) && (pat_mem[PAW'(pat_len - 1'b1)] == C_DOLLAR);
    core_len    = pat_len - PW'(head_anchor) - PW'(tail_anchor);
    if (core_len == '0 || 32'(core_len) > 32'(str_len)) begin
      ncand = '0;
    end else begin
      ncand = str_len - IDX_W'(core_len) + 1'b1;
    end
    cand_live = (cand_s < ncand);
  end

  // Comparator lanes: lane k checks core character k against S[s+k]
  for (genvar k = 0; k < PAT_MAX; k++) begin : g_lane
    logic [CHAR_W-1:0] core_ch;
    logic [CHAR_W-1:0] str_ch;
    logic [31:0]       str_idx;
    logic              lane_en;

    // The core starts one slot later when a head anchor occupies slot 0.
    if (k + 1 < PAT_MAX) begin : g_shift
      assign core_ch = head_anchor ? pat_mem[k+1] : pat_mem[k];
    end else begin : g_last
      assign core_ch = head_anchor ? '0 : pat_mem[k];
    end

    assign str_idx = 32'(cand_s) + 32'(k);
    assign str_ch  = (str_idx < 32'(STR_MAX)) ? str_mem[SAW'(str_idx)] : '0;
    assign lane_en = (32'(k) < 32'(core_len));

    sme_cmp_lane #(.CHAR_W(CHAR_W)) u_lane (
      .en     (lane_en),
      .pat_ch (core_ch),
      .str_ch (str_ch),
      .hit    (lane_hit[k])
    );
  end

  // Anchor checks use the raw string: separators are never folded.
  always_comb begin
    tail_idx    = 32'(cand_s) + 32'(core_len);
    head_ok     = !head_anchor || (cand_s == '0) ||
                  (str_mem[SAW'(cand_s - 1'b1)] == C_SPACE);
    tail_ok     = !tail_anchor || (tail_idx == 32'(str_len)) ||
                  ((tail_idx < 32'(STR_MAX)) && (str_mem[SAW'(tail_idx)] == C_SPACE));
    cand_hit_p0 = cand_live && (&lane_hit) && head_ok && tail_ok;
    // The cycle after the last candidate produces the terminator.
    search_end  = search_cyc && (!cand_live || (cand_hit_p0 && !find_all_r));
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, LOAD_STR: begin
        if (str_wr)      state_nxt = LOAD_STR;
        else if (pat_wr) state_nxt = LOAD_PAT;
        else             state_nxt = IDLE;
      end
      LOAD_PAT: begin
        if (ispattern)       state_nxt = LOAD_PAT;
        else if (search_end) state_nxt = IDLE;
        else                 state_nxt = SEARCH;
      end
      SEARCH: begin
        state_nxt = search_end ? IDLE : SEARCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy        = search_cyc;
    valid       = vld_p1;
    match       = match_p1;
    match_index = idx_p1;
    done        = done_p1;
  end

  // Load control and candidate counter
  always_ff @(posedge clk) begin
    if (reset) begin
      str_len    <= '0;
      pat_len    <= '0;
      cand_s     <= '0;
      find_all_r <= 1'b0;
    end else begin
      if (str_first) begin
        str_len <= IDX_W'(1);
      end else if (str_wr && 32'(str_len) < 32'(STR_MAX)) begin
        str_len <= str_len + 1'b1;
      end
      if (pat_first) begin
        pat_len    <= PW'(1);
        find_all_r <= find_all;
      end else if (pat_wr && 32'(pat_len) < 32'(PAT_MAX)) begin
        pat_len <= pat_len + 1'b1;
      end
      cand_s <= search_cyc ? cand_s + 1'b1 : '0;
    end
  end

  // Character storage; overflow characters are dropped
  always_ff @(posedge clk) begin
    if (str_first) begin
      str_mem[0] <= chardata;
    end else if (str_wr && 32'(str_len) < 32'(STR_MAX)) begin
      str_mem[SAW'(str_len)] <= chardata;
    end
    if (pat_first) begin
      pat_mem[0] <= chardata;
    end else if (pat_wr && 32'(pat_len) < 32'(PAT_MAX)) begin
      pat_mem[PAW'(pat_len)] <= chardata;
    end
  end

  // ---- p0 -> p1: candidate result register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      match_p1 <= 1'b0;
      idx_p1   <= '0;
      done_p1  <= 1'b0;
    end else begin
      vld_p1   <= 1'b0;
      match_p1 <= 1'b0;
      idx_p1   <= '0;
      done_p1  <= 1'b0;
      if (search_cyc) begin
        if (cand_live) begin
          if (cand_hit_p0) begin
            vld_p1   <= 1'b1;
            match_p1 <= 1'b1;
            idx_p1   <= cand_s;
            done_p1  <= !find_all_r;
          end
        end else begin
          vld_p1  <= 1'b1;
          done_p1 <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sme_multi.sv
// ---------------------------------------------------------------------------
// tb_sme_multi
// Self-checking bench for sme_multi: a table of directed vectors with
// hand-derived first results, hand-written reset and overflow sequences,
// and randomized string/pattern traffic checked cycle by cycle against a
// reference model that scans the string directly from the matching rules.
// ---------------------------------------------------------------------------
module tb_sme_multi;

  localparam int CHAR_W  = 8;
  localparam int STR_MAX = 32;
  localparam int PAT_MAX = 8;
  localparam int IDX_W   = $clog2(STR_MAX + 1);
  localparam int TMAX    = 40;

  logic              clk;
  logic              reset;
  logic [CHAR_W-1:0] chardata;
  logic              isstring;
  logic              ispattern;
  logic              find_all;
  logic              busy;
  logic              valid;
  logic              match;
  logic [IDX_W-1:0]  match_index;
  logic              done;

  sme_multi #(
    .CHAR_W (CHAR_W),
    .STR_MAX(STR_MAX),
    .PAT_MAX(PAT_MAX)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .chardata   (chardata),
    .isstring   (isstring),
    .ispattern  (ispattern),
    .find_all   (find_all),
    .busy       (busy),
    .valid      (valid),
    .match      (match),
    .match_index(match_index),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp;
  int n_fail;

  logic [7:0] tb_str [64];
  int         tb_slen;
  logic [7:0] tb_pat [16];
  int         tb_plen;

  logic [7:0] m_str [STR_MAX];
  int         m_len;

  // trace word: {busy, valid, match, done, match_index}
  logic [9:0] exp_tr [TMAX+1];
  logic [9:0] obs_tr [TMAX+1];
  int         t_end;
  int         obs_end;

  typedef struct {
    string s;
    bit    new_s;
    string p;
    bit    fa;
    int    t;
    bit    m;
    int    idx;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [9:0] pk(logic b, logic v, logic m, logic d, logic [5:0] i);
    return {b, v, m, d, i};
  endfunction

  function automatic logic [7:0] fold_m(logic [7:0] c);
`ifdef SME_CASE_FOLD_EN
    if (c >= "A" && c <= "Z") return c + 8'd32;
`endif
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic load_str(input string s);
    tb_slen = s.len();
    for (int i = 0; i < tb_slen; i++) tb_str[i] = s[i];
  endtask

  task automatic load_pat(input string s);
    tb_plen = s.len();
    for (int i = 0; i < tb_plen; i++) tb_pat[i] = s[i];
  endtask

  // Reference: scan every alignment of the core pattern over the stored
  // string and place each report at the cycle the timing rules give.
  task automatic model_search(input bit fa);
    logic [7:0] p [PAT_MAX];
    int  pn, c, nc, h, tl;
    bit  ok, found;
    pn = (tb_plen > PAT_MAX) ? PAT_MAX : tb_plen;
    for (int i = 0; i < pn; i++) p[i] = tb_pat[i];
    h  = (pn > 0 && p[0] == 8'h5E) ? 1 : 0;
    tl = (pn > h && p[pn-1] == 8'h24) ? 1 : 0;
    c  = pn - h - tl;
    nc = (c == 0 || c > m_len) ? 0 : m_len - c + 1;
    for (int t = 0; t <= TMAX; t++) exp_tr[t] = '0;
    found = 1'b0;
    t_end = -1;
    for (int s = 0; s < nc && t_end < 0; s++) begin
      ok = 1'b1;
      for (int k = 0; k < c; k++) begin
        if (!(p[h+k] == 8'h2E || fold_m(p[h+k]) == fold_m(m_str[s+k]))) ok = 1'b0;
      end
      if (h == 1 && s > 0 && m_str[s-1] != 8'h20) ok = 1'b0;
      if (tl == 1 && s + c != m_len && m_str[s+c] != 8'h20) ok = 1'b0;
      if (ok) begin
        found = 1'b1;
        exp_tr[s+1] = pk(1'b0, 1'b1, 1'b1, !fa, 6'(s));
        if (!fa) t_end = s + 1;
      end
    end
    if (t_end < 0) begin
      t_end = nc + 1;
      exp_tr[t_end] = pk(1'b0, 1'b1, 1'b0, 1'b1, 6'd0);
    end
    for (int t = 0; t < t_end; t++) exp_tr[t][9] = 1'b1;
  endtask

  task automatic send_string(input int gap);
    for (int i = 0; i < tb_slen; i++) begin
      @(posedge clk); #1;
      isstring  = 1'b1;
      ispattern = 1'b0;
      chardata  = tb_str[i];
    end
    if (gap > 0) begin
      @(posedge clk); #1;
      isstring = 1'b0;
      chardata = '0;
      repeat (gap - 1) @(posedge clk);
    end
    m_len = (tb_slen > STR_MAX) ? STR_MAX : tb_slen;
    for (int i = 0; i < m_len; i++) m_str[i] = tb_str[i];
  endtask

  // Leaves the bench in cycle T0 with all load inputs low.
  task automatic send_pattern(input bit fa);
    for (int i = 0; i < tb_plen; i++) begin
      @(posedge clk); #1;
      isstring  = 1'b0;
      ispattern = 1'b1;
      chardata  = tb_pat[i];
      find_all  = (i == 0) ? fa : !fa;
    end
    @(posedge clk); #1;
    ispattern = 1'b0;
    find_all  = 1'b0;
    chardata  = '0;
  endtask

  task automatic capture();
    bit stop;
    for (int t = 0; t <= TMAX; t++) obs_tr[t] = '0;
    #1;
    obs_tr[0] = pk(busy, valid, match, done, match_index);
    obs_end = -1;
    stop = 1'b0;
    for (int t = 1; t <= TMAX && !stop; t++) begin
      @(posedge clk); #1;
      obs_tr[t] = pk(busy, valid, match, done, match_index);
      if (done) begin
        obs_end = t;
        stop = 1'b1;
      end
    end
  endtask

  task automatic compare_trace(input string tag);
    check({tag, " done_cycle"}, obs_end, t_end);
    for (int t = 0; t <= t_end && t <= TMAX; t++) begin
      check($sformatf("%s trace t=%0d", tag, t), obs_tr[t], exp_tr[t]);
    end
  endtask

  function automatic int first_valid();
    for (int t = 0; t <= TMAX; t++) if (obs_tr[t][8]) return t;
    return -1;
  endfunction

  task automatic run_case(input string tag, input bit new_s, input int gap, input bit fa);
    if (new_s) send_string(gap);
    model_search(fa);
    send_pattern(fa);
    capture();
    compare_trace(tag);
  endtask

  initial begin
    int fv;
    n_cmp     = 0;
    n_fail    = 0;
    m_len     = 0;
    reset     = 1'b1;
    isstring  = 1'b0;
    ispattern = 1'b0;
    find_all  = 1'b0;
    chardata  = '0;

    vecs[0] = '{"the cat sat", 1'b1, "at",    1'b0, 6,  1'b1, 5};
    vecs[1] = '{"",            1'b0, "at",    1'b1, 6,  1'b1, 5};
    vecs[2] = '{"",            1'b0, "^sat$", 1'b0, 9,  1'b1, 8};
    vecs[3] = '{"",            1'b0, "^at",   1'b0, 11, 1'b0, 0};
    vecs[4] = '{"",            1'b0, "c.t",   1'b0, 5,  1'b1, 4};
    vecs[5] = '{"",            1'b0, "h",     1'b0, 2,  1'b1, 1};
`ifdef SME_CASE_FOLD_EN
    vecs[6] = '{"THE",         1'b1, "the",   1'b0, 1,  1'b1, 0};
`else
    vecs[6] = '{"THE",         1'b1, "the",   1'b0, 2,  1'b0, 0};
`endif
    vecs[7] = '{"the cat sat", 1'b1, "^",     1'b0, 1,  1'b0, 0};
    vecs[8] = '{"",            1'b0, "sat$",  1'b1, 9,  1'b1, 8};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", pk(busy, valid, match, done, match_index), 10'd0);
    reset = 1'b0;

    // Directed table
    for (int v = 0; v < 9; v++) begin
      if (vecs[v].new_s) load_str(vecs[v].s);
      load_pat(vecs[v].p);
      run_case($sformatf("vec%0d", v), vecs[v].new_s, v % 2, vecs[v].fa);
      fv = first_valid();
      check($sformatf("vec%0d first_valid_cycle", v), fv, vecs[v].t);
      if (fv >= 0) begin
        check($sformatf("vec%0d match", v), obs_tr[fv][7], vecs[v].m);
        check($sformatf("vec%0d index", v), obs_tr[fv][5:0], vecs[v].idx);
      end
    end

    // Find-all second hit and terminator on "the cat sat" / "at"
    load_str("the cat sat");
    load_pat("at");
    run_case("findall", 1'b1, 0, 1'b1);
    check("findall idx9 at T0+10", obs_tr[10], pk(1'b1, 1'b1, 1'b1, 1'b0, 6'd9));
    check("findall term at T0+11", obs_tr[11], pk(1'b0, 1'b1, 1'b0, 1'b1, 6'd0));

    // Reset in the middle of a search
    load_pat("zz");
    send_pattern(1'b1);
    #1;
    check("midreset busy T0", busy, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset outputs T0+4", pk(busy, valid, match, done, match_index), 10'd0);
    reset = 1'b0;
    m_len = 0;
    load_pat("a");
    run_case("after_reset_empty_string", 1'b0, 0, 1'b0);
    check("after_reset terminator cycle", obs_end, 1);

    // String overflow: 40 characters, only the first 32 are kept
    for (int i = 0; i < 31; i++) tb_str[i] = (i % 2 == 1) ? "b" : "a";
    tb_str[31] = "z";
    for (int i = 32; i < 40; i++) tb_str[i] = 8'h30 + 8'(i - 32);
    tb_slen = 40;
    load_pat("01234567");
    run_case("ovf_dropped", 1'b1, 1, 1'b0);
    check("ovf_dropped no-match cycle", obs_end, 26);
    check("ovf_dropped match flag", obs_tr[26][7], 1'b0);
    load_pat("z$");
    run_case("ovf_len32", 1'b0, 0, 1'b0);
    check("ovf_len32 result", obs_tr[32], pk(1'b0, 1'b1, 1'b1, 1'b1, 6'd31));

    // Randomized traffic against the reference model
    for (int it = 0; it < 40; it++) begin
      bit new_s;
      int core, h, tl, n;
      new_s = (it == 0) || ($urandom_range(0, 2) != 0);
      if (new_s) begin
        tb_slen = $urandom_range(1, 36);
        for (int i = 0; i < tb_slen; i++) begin
          case ($urandom_range(0, 4))
            0, 1:    tb_str[i] = "a";
            2:       tb_str[i] = "b";
            3:       tb_str[i] = " ";
            default: tb_str[i] = "A";
          endcase
        end
      end
      h    = $urandom_range(0, 1);
      tl   = $urandom_range(0, 1);
      core = ($urandom_range(0, 5) == 0) ? $urandom_range(5, 9) : $urandom_range(0, 3);
      n = 0;
      if (h == 1) begin tb_pat[n] = "^"; n++; end
      for (int k = 0; k < core; k++) begin
        case ($urandom_range(0, 3))
          0:       tb_pat[n] = ".";
          1:       tb_pat[n] = "b";
          default: tb_pat[n] = "a";
        endcase
        n++;
      end
      if (tl == 1) begin tb_pat[n] = "$"; n++; end
      if (n == 0) begin tb_pat[0] = "a"; n = 1; end
      tb_plen = n;
      run_case($sformatf("rand%0d", it), new_s, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
